// File: rtl/cobs_package.sv
`default_nettype none
// ============================================================================
//  Module      : cobs_package
//  Description : Definitions shared by the COBS encoder and decoder. This
//                covers the frame delimiter, the largest code byte and the
//                decoder state type.
//  Revision    : 1.0  initial release
// ============================================================================
package cobs_package;

    localparam logic [7:0] COBS_DELIMITER = 8'h00;
    localparam logic [7:0] COBS_MAX_CODE  = 8'hFF;

    typedef enum logic [1:0] {
        COBS_CODE    = 2'd0,
        COBS_DATA    = 2'd1,
        COBS_DISCARD = 2'd2
    } cobs_dec_state_t;

endpackage
`default_nettype wire

// File: rtl/cobs_axis_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : cobs_axis_decoder
//  Description : Removes COBS framing from the host->device byte stream.
//                The input is a 0x00-delimited encoded stream on 8-bit AXIS.
//                The output is decoded payload packets on 8-bit AXIS, with
//                tlast on the final byte and tuser=1 on the tlast beat of a
//                corrupt or truncated frame.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                s_axis_t*           - encoded byte stream in
//                m_axis_t*           - decoded payload out (tlast/tuser)
//                frame_done          - pulse after a good frame's last beat
//                                      is accepted downstream
//                frame_err           - pulse on truncation/oversize error
//  Revision    : 1.0  initial release
// ============================================================================
module cobs_axis_decoder
    import cobs_package::*;
#(
    parameter int MAX_FRAME_BYTES = 1024
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int                 COUNT_W     = $clog2(MAX_FRAME_BYTES + 1);
    localparam logic [COUNT_W-1:0] C_COUNT_MAX = COUNT_W'(MAX_FRAME_BYTES);

    cobs_dec_state_t    r_state;
    cobs_dec_state_t    w_next_state;

    // The hold register keeps one decoded byte back until the next input
    // byte reveals whether that byte ends the frame.
    logic               r_hold_valid;
    logic [7:0]         r_hold_data;
    logic               r_zero_pend;
    logic [7:0]         r_rem;
    logic [COUNT_W-1:0] r_count;

    logic               r_out_valid;
    logic [7:0]         r_out_data;
    logic               r_out_last;
    logic               r_out_user;
    logic               r_frame_done;
    logic               r_frame_err;

    logic               w_s_ready;
    logic               w_accept;
    logic               w_is_delim;
    logic               w_out_take;

    logic               w_push_req;
    logic [7:0]         w_push_data;
    logic               w_flush_req;
    logic               w_flush_user_req;
    logic               w_err_req;
    logic               w_clear;
    logic               w_load_code;
    logic               w_rem_dec;

    logic               w_overflow;
    logic               w_push;
    logic               w_flush;
    logic               w_flush_user;
    logic               w_err;

    // Every accepted byte moves at most one byte from hold to out. Input
    // stalls whenever out is occupied and not draining, so a push or flush
    // always finds room in out.
    assign w_s_ready  = !rst && (!r_out_valid || m_axis_tready);
    assign w_accept   = s_axis_tvalid && w_s_ready;
    assign w_is_delim = (s_axis_tdata == COBS_DELIMITER);
    assign w_out_take = r_out_valid && m_axis_tready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COBS_CODE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            case (r_state)
                COBS_CODE: begin
                    if (!w_is_delim) begin
                        if (w_overflow) begin
                            w_next_state = COBS_DISCARD;
                        end else if (s_axis_tdata != 8'h01) begin
                            w_next_state = COBS_DATA;
                        end
                    end
                end
                COBS_DATA: begin
                    if (w_is_delim) begin
                        w_next_state = COBS_CODE;
                    end else if (w_overflow) begin
                        w_next_state = COBS_DISCARD;
                    end else if (r_rem == 8'd1) begin
                        w_next_state = COBS_CODE;
                    end
                end
                COBS_DISCARD: begin
                    if (w_is_delim) begin
                        w_next_state = COBS_CODE;
                    end
                end
                default: w_next_state = COBS_CODE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_push_req       = 1'b0;
        w_push_data      = s_axis_tdata;
        w_flush_req      = 1'b0;
        w_flush_user_req = 1'b0;
        w_err_req        = 1'b0;
        w_clear          = 1'b0;
        w_load_code      = 1'b0;
        w_rem_dec        = 1'b0;
        if (w_accept) begin
            case (r_state)
                COBS_CODE: begin
                    if (w_is_delim) begin
                        w_flush_req = 1'b1;
                        w_clear     = 1'b1;
                    end else begin
                        // The zero implied by the previous short block is
                        // only real once another block follows it.
                        w_push_req  = r_zero_pend;
                        w_push_data = COBS_DELIMITER;
                        w_load_code = 1'b1;
                    end
                end
                COBS_DATA: begin
                    if (w_is_delim) begin
                        w_flush_req      = 1'b1;
                        w_flush_user_req = 1'b1;
                        w_err_req        = 1'b1;
                        w_clear          = 1'b1;
                    end else begin
                        w_push_req = 1'b1;
                        w_rem_dec  = 1'b1;
                    end
                end
                COBS_DISCARD: begin
                    w_clear = w_is_delim;
                end
                default: ;
            endcase
        end
    end

    // A push past the limit becomes a corrupt-frame flush instead.
    assign w_overflow   = w_push_req && (r_count == C_COUNT_MAX);
    assign w_push       = w_push_req && !w_overflow;
    assign w_flush      = (w_flush_req || w_overflow) && r_hold_valid;
    assign w_flush_user = w_flush_user_req || w_overflow;
    assign w_err        = w_err_req || w_overflow;

    // ------------------------------------------------------------------
    // Hold / out datapath and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= 8'h00;
            r_zero_pend  <= 1'b0;
            r_rem        <= 8'h00;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_last   <= 1'b0;
            r_out_user   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= w_out_take && r_out_last && !r_out_user;
            r_frame_err  <= w_err;

            if (w_out_take) begin
                r_out_valid <= 1'b0;
            end

            if (w_push) begin
                if (r_hold_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_hold_data;
                    r_out_last  <= 1'b0;
                    r_out_user  <= 1'b0;
                end
                r_hold_data  <= w_push_data;
                r_hold_valid <= 1'b1;
                r_count      <= r_count + 1'b1;
            end else if (w_flush) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_hold_data;
                r_out_last   <= 1'b1;
                r_out_user   <= w_flush_user;
                r_hold_valid <= 1'b0;
            end

            if (w_load_code) begin
                r_rem       <= s_axis_tdata - 8'd1;
                r_zero_pend <= (s_axis_tdata != COBS_MAX_CODE);
            end
            if (w_rem_dec) begin
                r_rem <= r_rem - 8'd1;
            end
            // Frame end or abort: forget the pending zero and the byte count.
            if (w_clear || w_overflow) begin
                r_count     <= '0;
                r_zero_pend <= 1'b0;
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = r_out_user;
    assign frame_done    = r_frame_done;
    assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_cobs_axis_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cobs_axis_decoder
//  Description : Self-checking bench for cobs_axis_decoder. It uses a
//                default-size instance and a MAX_FRAME_BYTES=4 instance,
//                and sel steers the input stream to one of them. Expected
//                beats are queued when frames are sent. A monitor pops the
//                queue and compares each accepted output beat.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cobs_axis_decoder;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       m_tready;
    logic       sel;
    logic       rand_ready;

    logic       b_s_tready, b_m_tvalid, b_m_tlast, b_m_tuser, b_done, b_err;
    logic [7:0] b_m_tdata;
    logic       t_s_tready, t_m_tvalid, t_m_tlast, t_m_tuser, t_done, t_err;
    logic [7:0] t_m_tdata;

    logic       s_tready, m_tvalid, m_tlast, m_tuser;
    logic [7:0] m_tdata;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    obs_done = 0, obs_err = 0;
    int    exp_done = 0, exp_err = 0;

    always #5 clk = ~clk;

    cobs_axis_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid & ~sel),
        .s_axis_tready (b_s_tready),
        .m_axis_tdata  (b_m_tdata),
        .m_axis_tvalid (b_m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (b_m_tlast),
        .m_axis_tuser  (b_m_tuser),
        .frame_done    (b_done),
        .frame_err     (b_err)
    );

    cobs_axis_decoder #(.MAX_FRAME_BYTES(4)) dut_small (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid & sel),
        .s_axis_tready (t_s_tready),
        .m_axis_tdata  (t_m_tdata),
        .m_axis_tvalid (t_m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (t_m_tlast),
        .m_axis_tuser  (t_m_tuser),
        .frame_done    (t_done),
        .frame_err     (t_err)
    );

    assign s_tready = sel ? t_s_tready : b_s_tready;
    assign m_tvalid = sel ? t_m_tvalid : b_m_tvalid;
    assign m_tdata  = sel ? t_m_tdata  : b_m_tdata;
    assign m_tlast  = sel ? t_m_tlast  : b_m_tlast;
    assign m_tuser  = sel ? t_m_tuser  : b_m_tuser;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Downstream ready: always 1, or about 30% duty in backpressure mode.
    initial m_tready = 1'b1;
    always @(posedge clk) begin
        #1;
        m_tready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (b_done | t_done) obs_done++;
            if (b_err | t_err)   obs_err++;
            if (m_tvalid && !m_tready) chk("stall_tready", s_tready, 1'b0);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %02h last %0b user %0b, expected none",
                             m_tdata, m_tlast, m_tuser);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", m_tdata, e.data);
                    chk("beat_last", m_tlast, e.last);
                    chk("beat_user", m_tuser, e.user);
                end
            end
        end
    end

    task automatic expect_beat(input logic [7:0] d, input logic l, input logic u);
        beat_t e;
        e.data = d;
        e.last = l;
        e.user = u;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bit hs;
        s_tdata  = b;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            if (hs) break;
            n++;
            if (n > 2000) begin
                total++;
                bad++;
                $display("FAIL send_timeout: byte %02h never accepted, expected accept", b);
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_done_cnt"}, obs_done, exp_done);
        chk({name, "_err_cnt"}, obs_err, exp_err);
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_s_tready", s_tready, 1'b1);
        chk("rst_done", b_done | t_done, 1'b0);
        chk("rst_err", b_err | t_err, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic case1_frame();
        expect_beat(8'h11, 1'b0, 1'b0);
        expect_beat(8'h22, 1'b0, 1'b0);
        expect_beat(8'h00, 1'b0, 1'b0);
        expect_beat(8'h33, 1'b1, 1'b0);
        exp_done++;
        send_list('{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00});
    endtask

    initial begin
        rst        = 1'b1;
        s_tdata    = 8'h00;
        s_tvalid   = 1'b0;
        sel        = 1'b0;
        rand_ready = 1'b0;
        do_reset();

        // 1: basic frame with an embedded zero
        case1_frame();
        drain("c1");

        // 2: maximal block, no implied zero after a 0xFF code
        for (int i = 1; i <= 254; i++) expect_beat(8'(i), (i == 254), 1'b0);
        exp_done++;
        send(8'hFF);
        for (int i = 1; i <= 254; i++) send(8'(i));
        send(8'h00);
        drain("c2");

        // 3: frame that decodes to one zero byte, then stray delimiters
        expect_beat(8'h00, 1'b1, 1'b0);
        exp_done++;
        send_list('{8'h01, 8'h01, 8'h00});
        send_list('{8'h00, 8'h00});
        drain("c3");

        // 4: truncated block, then a clean frame
        expect_beat(8'hAA, 1'b0, 1'b0);
        expect_beat(8'hBB, 1'b1, 1'b1);
        exp_err++;
        send_list('{8'h05, 8'hAA, 8'hBB, 8'h00});
        expect_beat(8'h44, 1'b1, 1'b0);
        exp_done++;
        send_list('{8'h02, 8'h44, 8'h00});
        drain("c4");

        // 5: oversize frame on the 4-byte instance
        sel = 1'b1;
        expect_beat(8'h01, 1'b0, 1'b0);
        expect_beat(8'h02, 1'b0, 1'b0);
        expect_beat(8'h03, 1'b0, 1'b0);
        expect_beat(8'h04, 1'b1, 1'b1);
        exp_err++;
        send_list('{8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00});
        expect_beat(8'h44, 1'b1, 1'b0);
        exp_done++;
        send_list('{8'h02, 8'h44, 8'h00});
        drain("c5");
        sel = 1'b0;

        // 6: backpressure, reset mid-frame, then a clean frame
        rand_ready = 1'b1;
        case1_frame();
        drain("c6a");
        send_list('{8'h03, 8'h11});
        do_reset();
        case1_frame();
        drain("c6b");
        rand_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
